// File: rtl/ahb_apb_bridge_fsm_pkg.sv
// Shared AHB-to-APB bridge definitions: FSM state encoding and the APB address map.
// Also imported by ahb_slave_interface so both sides agree on the map.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WWAIT    = 3'd1,
    READ     = 3'd2,
    WRITE    = 3'd3,
    WRITEP   = 3'd4,
    RENABLE  = 3'd5,
    WENABLE  = 3'd6,
    WENABLEP = 3'd7
  } state_e;

  localparam int          MAP_NSLV  = 3;
  localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
  localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
  localparam logic [31:0] SLV2_BASE = 32'h8800_0000;
  localparam logic [31:0] MAP_END   = 32'h8C00_0000;

  // One-hot peripheral select; each slot is [base, next base).
  function automatic logic [MAP_NSLV-1:0] decode(input logic [31:0] addr);
    logic [MAP_NSLV-1:0] sel;
    sel = '0;
    if (addr >= SLV0_BASE && addr < SLV1_BASE)
      sel = 3'b001;
    else if (addr >= SLV1_BASE && addr < SLV2_BASE)
      sel = 3'b010;
    else if (addr >= SLV2_BASE && addr < MAP_END)
      sel = 3'b100;
    return sel;
  endfunction

endpackage

// File: rtl/ahb_apb_bridge.sv
// AHB-to-APB bridge controller: turns each accepted AHB beat into an APB
// SETUP/ENABLE pair and stalls the AHB master through Hreadyout.
module ahb_apb_bridge_fsm
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 3
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              valid,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [ADDR_W-1:0] Haddr1,
  input  logic [ADDR_W-1:0] Haddr2,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Hwdata1,
  input  logic              Hwrite,
  input  logic              Hwrite_reg,
  input  logic [DATA_W-1:0] Prdata,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout,
  output logic [DATA_W-1:0] Hrdata
);

  state_e              state, next_state;
  logic [NSLV-1:0]     psel_nxt;
  logic                penable_nxt, pwrite_nxt, hready_nxt;
  logic [ADDR_W-1:0]   paddr_nxt, wr_addr;
  logic [DATA_W-1:0]   pwdata_nxt, wr_data;

  assign Hrdata = Prdata;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state  = state;
    psel_nxt    = Pselx;
    penable_nxt = Penable;
    pwrite_nxt  = Pwrite;
    paddr_nxt   = Paddr;
    pwdata_nxt  = Pwdata;
    hready_nxt  = Hreadyout;
    // A pipelined write re-entering SETUP from WENABLEP is two beats behind the live bus.
    wr_addr     = (state == WENABLEP) ? Haddr2  : Haddr1;
    wr_data     = (state == WENABLEP) ? Hwdata1 : Hwdata;

    case (state)
      IDLE, RENABLE, WENABLE: begin
        if (valid && Hwrite)  next_state = WWAIT;
        else if (valid)       next_state = READ;
        else                  next_state = IDLE;
      end
      WWAIT:    next_state = valid ? WRITEP : WRITE;
      READ:     next_state = RENABLE;
      WRITE:    next_state = valid ? WENABLEP : WENABLE;
      WRITEP:   next_state = WENABLEP;
      WENABLEP: begin
        if (!Hwrite_reg) next_state = READ;
        else if (valid)  next_state = WRITEP;
        else             next_state = WRITE;
      end
      default:  next_state = IDLE;
    endcase

    case (next_state)
      IDLE, WWAIT: begin
        psel_nxt    = '0;
        penable_nxt = 1'b0;
        hready_nxt  = 1'b1;
      end
      READ: begin
        paddr_nxt   = Haddr;
        pwrite_nxt  = 1'b0;
        psel_nxt    = NSLV'(decode(32'(Haddr)));
        penable_nxt = 1'b0;
        hready_nxt  = 1'b0;
      end
      WRITE, WRITEP: begin
        paddr_nxt   = wr_addr;
        pwdata_nxt  = wr_data;
        pwrite_nxt  = 1'b1;
        psel_nxt    = NSLV'(decode(32'(wr_addr)));
        penable_nxt = 1'b0;
        hready_nxt  = (next_state == WRITE);
      end
      RENABLE, WENABLE, WENABLEP: begin
        penable_nxt = 1'b1;
        hready_nxt  = 1'b1;
      end
      default: begin
        psel_nxt    = '0;
        penable_nxt = 1'b0;
        hready_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      Pselx     <= '0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Hreadyout <= 1'b1;
    end else begin
      Pselx     <= psel_nxt;
      Penable   <= penable_nxt;
      Pwrite    <= pwrite_nxt;
      Paddr     <= paddr_nxt;
      Pwdata    <= pwdata_nxt;
      Hreadyout <= hready_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_fsm.sv
// Bench for ahb_apb_bridge_fsm: directed AHB beats, with an APB-side monitor
// that pops expected transfers from a scoreboard on every ENABLE cycle.
module tb_ahb_apb_bridge_fsm;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        valid;
  logic [31:0] Haddr, Haddr1, Haddr2, Hwdata, Hwdata1;
  logic        Hwrite, Hwrite_reg;
  logic [31:0] Prdata;
  logic [2:0]  Pselx;
  logic        Penable, Pwrite, Hreadyout;
  logic [31:0] Paddr, Pwdata, Hrdata;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [2:0]  sel;
    logic [31:0] rdata;
  } xfer_t;
  xfer_t exp_q[$];

  logic [2:0]  prev_sel;
  logic        prev_pen, prev_pwrite;
  logic [31:0] prev_addr, prev_wdata;

  ahb_apb_bridge_fsm #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .valid(valid),
    .Haddr(Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2),
    .Hwdata(Hwdata), .Hwdata1(Hwdata1), .Hwrite(Hwrite), .Hwrite_reg(Hwrite_reg),
    .Prdata(Prdata), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Hreadyout(Hreadyout), .Hrdata(Hrdata)
  );

  always #5 HCLK = ~HCLK;

  // APB monitor: every ENABLE cycle must match the oldest expected transfer
  // and repeat the preceding SETUP cycle's address, direction, data and select.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      prev_pen = 1'b0; prev_sel = '0; prev_addr = '0; prev_wdata = '0; prev_pwrite = 1'b0;
    end else begin
      if (Penable === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL apb_unexpected_enable got addr=%h sel=%b required no transfer", Paddr, Pselx);
        end else begin
          xfer_t e;
          e = exp_q.pop_front();
          if (Paddr !== e.addr || Pwrite !== e.write || Pselx !== e.sel ||
              (e.write && Pwdata !== e.wdata) || (!e.write && Hrdata !== e.rdata))
            $display("FAIL apb_xfer got addr=%h wr=%b sel=%b wdata=%h rdata=%h required addr=%h wr=%b sel=%b wdata=%h rdata=%h",
                     Paddr, Pwrite, Pselx, Pwdata, Hrdata, e.addr, e.write, e.sel, e.wdata, e.rdata);
          else
            passed++;
        end
        total++;
        if (prev_pen !== 1'b0 || prev_sel !== Pselx || prev_addr !== Paddr ||
            prev_pwrite !== Pwrite || prev_wdata !== Pwdata)
          $display("FAIL apb_setup_stable got prev pen=%b sel=%b addr=%h wr=%b wdata=%h required pen=0 sel=%b addr=%h wr=%b wdata=%h",
                   prev_pen, prev_sel, prev_addr, prev_pwrite, prev_wdata, Pselx, Paddr, Pwrite, Pwdata);
        else
          passed++;
      end
      prev_pen = Penable; prev_sel = Pselx; prev_addr = Paddr;
      prev_wdata = Pwdata; prev_pwrite = Pwrite;
    end
  end

  // One bus cycle: shift the slave-interface delay stages, drive the live beat, then advance.
  task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    Haddr2 = Haddr1; Haddr1 = Haddr; Hwdata1 = Hwdata; Hwrite_reg = Hwrite;
    valid = v; Hwrite = w; Haddr = a; Hwdata = d;
    @(posedge HCLK); #1;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [2:0] s, input logic [31:0] rd);
    xfer_t e;
    e.addr = a; e.write = w; e.wdata = wd; e.sel = s; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic clear_bus();
    valid = 0; Hwrite = 0; Haddr = '0; Hwdata = '0;
    Haddr1 = '0; Haddr2 = '0; Hwdata1 = '0; Hwrite_reg = 0; Prdata = '0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    clear_bus();
    repeat (2) @(posedge HCLK);
    #1;
    total++;
    if ({Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout} !== {3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1})
      $display("FAIL reset_values got sel=%b pen=%b wr=%b addr=%h wdata=%h rdy=%b required 000 0 0 0 0 1",
               Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout);
    else passed++;
    HRESETn = 1'b1;
    step(0, 0, 32'h0, 32'h0);
    total++;
    if ({Pselx, Penable, Hreadyout} !== {3'b000, 1'b0, 1'b1})
      $display("FAIL reset_idle got sel=%b pen=%b rdy=%b required 000 0 1", Pselx, Penable, Hreadyout);
    else passed++;
  endtask

  task automatic test_single_write();
    push_exp(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 3'b001, 32'h0);
    step(1, 1, 32'h8000_0010, 32'h0);
    total++;
    if ({Pselx, Penable, Hreadyout} !== {3'b000, 1'b0, 1'b1})
      $display("FAIL wr_wwait got sel=%b pen=%b rdy=%b required 000 0 1", Pselx, Penable, Hreadyout);
    else passed++;
    step(0, 1, 32'h0, 32'hDEAD_BEEF);
    total++;
    if ({Pselx, Pwrite, Paddr, Pwdata, Penable, Hreadyout} !== {3'b001, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1})
      $display("FAIL wr_setup got sel=%b wr=%b addr=%h wdata=%h pen=%b rdy=%b required 001 1 80000010 deadbeef 0 1",
               Pselx, Pwrite, Paddr, Pwdata, Penable, Hreadyout);
    else passed++;
    step(0, 1, 32'h0, 32'h0);
    total++;
    if ({Penable, Pselx} !== {1'b1, 3'b001})
      $display("FAIL wr_enable got pen=%b sel=%b required 1 001", Penable, Pselx);
    else passed++;
    step(0, 1, 32'h0, 32'h0);
    total++;
    if ({Penable, Pselx, Paddr} !== {1'b0, 3'b000, 32'h8000_0010})
      $display("FAIL wr_idle got pen=%b sel=%b addr=%h required 0 000 80000010", Penable, Pselx, Paddr);
    else passed++;
  endtask

  task automatic test_single_read();
    Prdata = 32'h1234_5678;
    push_exp(32'h8400_0004, 1'b0, 32'h0, 3'b010, 32'h1234_5678);
    step(1, 0, 32'h8400_0004, 32'h0);
    total++;
    if ({Pselx, Pwrite, Paddr, Penable, Hreadyout} !== {3'b010, 1'b0, 32'h8400_0004, 1'b0, 1'b0})
      $display("FAIL rd_setup got sel=%b wr=%b addr=%h pen=%b rdy=%b required 010 0 84000004 0 0",
               Pselx, Pwrite, Paddr, Penable, Hreadyout);
    else passed++;
    step(0, 0, 32'h0, 32'h0);
    total++;
    if ({Penable, Hrdata, Hreadyout} !== {1'b1, 32'h1234_5678, 1'b1})
      $display("FAIL rd_enable got pen=%b rdata=%h rdy=%b required 1 12345678 1", Penable, Hrdata, Hreadyout);
    else passed++;
    step(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0, a1, a2;
    a0 = 32'h8800_0000; a1 = 32'h8800_0004; a2 = 32'h8800_0008;
    push_exp(a0, 1'b1, 32'd1, 3'b100, 32'h0);
    push_exp(a1, 1'b1, 32'd2, 3'b100, 32'h0);
    push_exp(a2, 1'b1, 32'd3, 3'b100, 32'h0);
    step(1, 1, a0, 32'h0);
    step(1, 1, a1, 32'd1);
    total++;
    if ({Hreadyout, Penable, Paddr, Pwdata} !== {1'b0, 1'b0, a0, 32'd1})
      $display("FAIL b2b_writep0 got rdy=%b pen=%b addr=%h wdata=%h required 0 0 %h 1", Hreadyout, Penable, Paddr, Pwdata, a0);
    else passed++;
    step(1, 1, a2, 32'd2);
    step(1, 1, a2, 32'd2);
    total++;
    if ({Hreadyout, Penable, Paddr, Pwdata} !== {1'b0, 1'b0, a1, 32'd2})
      $display("FAIL b2b_writep1 got rdy=%b pen=%b addr=%h wdata=%h required 0 0 %h 2", Hreadyout, Penable, Paddr, Pwdata, a1);
    else passed++;
    step(0, 1, 32'h0, 32'd3);
    step(0, 1, 32'h0, 32'd3);
    total++;
    if ({Hreadyout, Penable, Paddr, Pwdata} !== {1'b1, 1'b0, a2, 32'd3})
      $display("FAIL b2b_write2 got rdy=%b pen=%b addr=%h wdata=%h required 1 0 %h 3", Hreadyout, Penable, Paddr, Pwdata, a2);
    else passed++;
    step(0, 1, 32'h0, 32'h0);
    step(0, 1, 32'h0, 32'h0);
  endtask

  task automatic test_write_then_read();
    Prdata = 32'h55AA_1234;
    push_exp(32'h8000_0000, 1'b1, 32'hCAFE_0001, 3'b001, 32'h0);
    push_exp(32'h8000_0004, 1'b0, 32'h0, 3'b001, 32'h55AA_1234);
    step(1, 1, 32'h8000_0000, 32'h0);
    step(1, 0, 32'h8000_0004, 32'hCAFE_0001);
    step(1, 0, 32'h8000_0004, 32'hCAFE_0001);
    total++;
    if ({Penable, Pwrite, Paddr} !== {1'b1, 1'b1, 32'h8000_0000})
      $display("FAIL wr_rd_wenablep got pen=%b wr=%b addr=%h required 1 1 80000000", Penable, Pwrite, Paddr);
    else passed++;
    step(1, 0, 32'h8000_0004, 32'h0);
    total++;
    if ({Penable, Pwrite, Paddr, Pselx, Hreadyout} !== {1'b0, 1'b0, 32'h8000_0004, 3'b001, 1'b0})
      $display("FAIL wr_rd_setup got pen=%b wr=%b addr=%h sel=%b rdy=%b required 0 0 80000004 001 0",
               Penable, Pwrite, Paddr, Pselx, Hreadyout);
    else passed++;
    step(0, 0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid_read();
    Prdata = 32'hFFFF_0000;
    step(1, 0, 32'h8800_0020, 32'h0);
    step(0, 0, 32'h0, 32'h0);
    total++;
    if (Penable !== 1'b1)
      $display("FAIL midrst_pre got pen=%b required 1", Penable);
    else passed++;
    #1 HRESETn = 1'b0;
    #1;
    total++;
    if ({Penable, Pselx, Hreadyout, Paddr, Pwrite} !== {1'b0, 3'b000, 1'b1, 32'h0, 1'b0})
      $display("FAIL midrst_async got pen=%b sel=%b rdy=%b addr=%h wr=%b required 0 000 1 0 0",
               Penable, Pselx, Hreadyout, Paddr, Pwrite);
    else passed++;
    @(posedge HCLK); #1;
    clear_bus();
    HRESETn = 1'b1;
    Prdata = 32'h0BAD_F00D;
    push_exp(32'h8400_0008, 1'b0, 32'h0, 3'b010, 32'h0BAD_F00D);
    step(1, 0, 32'h8400_0008, 32'h0);
    total++;
    if ({Pselx, Paddr, Hreadyout} !== {3'b010, 32'h8400_0008, 1'b0})
      $display("FAIL midrst_new_read got sel=%b addr=%h rdy=%b required 010 84000008 0", Pselx, Paddr, Hreadyout);
    else passed++;
    step(0, 0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_out_of_map();
    push_exp(32'h9000_0000, 1'b1, 32'hA5A5_5A5A, 3'b000, 32'h0);
    step(1, 1, 32'h9000_0000, 32'h0);
    step(0, 1, 32'h0, 32'hA5A5_5A5A);
    total++;
    if ({Pselx, Pwrite, Paddr, Penable} !== {3'b000, 1'b1, 32'h9000_0000, 1'b0})
      $display("FAIL oom_setup got sel=%b wr=%b addr=%h pen=%b required 000 1 90000000 0", Pselx, Pwrite, Paddr, Penable);
    else passed++;
    step(0, 1, 32'h0, 32'h0);
    total++;
    if ({Pselx, Penable} !== {3'b000, 1'b1})
      $display("FAIL oom_enable got sel=%b pen=%b required 000 1", Pselx, Penable);
    else passed++;
    step(0, 1, 32'h0, 32'h0);
  endtask

  task automatic test_decode_bounds();
    logic [31:0] tbl_addr [0:6];
    logic [2:0]  tbl_sel  [0:6];
    tbl_addr = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h83FF_FFFF, 32'h8400_0000,
                 32'h8800_0000, 32'h8BFF_FFFF, 32'h8C00_0000};
    tbl_sel  = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b000};
    for (int i = 0; i < 7; i++) begin
      Prdata = 32'h1000_0000 + i;
      push_exp(tbl_addr[i], 1'b0, 32'h0, tbl_sel[i], 32'h1000_0000 + i);
      step(1, 0, tbl_addr[i], 32'h0);
      total++;
      if (Pselx !== tbl_sel[i])
        $display("FAIL decode_%0d got sel=%b for addr=%h required %b", i, Pselx, tbl_addr[i], tbl_sel[i]);
      else passed++;
      step(0, 0, 32'h0, 32'h0);
      step(0, 0, 32'h0, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_write_then_read();
    test_reset_mid_read();
    test_out_of_map();
    test_decode_bounds();
    repeat (2) @(posedge HCLK);
    #1;
    total++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain got %0d pending transfers required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge_fsm.md
Name: ahb_apb_bridge_fsm

Overview:
- Controller that sequences APB transfers from the pipelined AHB slave-side datapath (registered address, write-data and direction stages).
- Converts each valid AHB beat into a two-phase APB transfer: SETUP, then ENABLE.
- Drives Hreadyout to stall the AHB master while an APB access is outstanding. Supports back-to-back (pipelined) writes.
- Sits between ahb_slave_interface and the three APB peripherals.

Parameters:
- ADDR_W, 32, AHB/APB address width
- DATA_W, 32, AHB/APB data width
- NSLV, 3, number of APB peripherals (one-hot Pselx width)

Ports:
- HCLK  in  1  system clock, all state on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- valid  in  1  current AHB beat is a valid transfer to the APB map
- Haddr  in  ADDR_W  live AHB address
- Haddr1  in  ADDR_W  address delayed 1 cycle
- Haddr2  in  ADDR_W  address delayed 2 cycles
- Hwdata  in  DATA_W  live AHB write data
- Hwdata1  in  DATA_W  write data delayed 1 cycle
- Hwrite  in  1  live transfer direction
- Hwrite_reg  in  1  direction delayed 1 cycle
- Prdata  in  DATA_W  APB read data
- Pselx  out  NSLV  one-hot peripheral select
- Penable  out  1  APB enable phase
- Pwrite  out  1  APB direction
- Paddr  out  ADDR_W  APB address
- Pwdata  out  DATA_W  APB write data
- Hreadyout  out  1  AHB ready, low = stall
- Hrdata  out  DATA_W  AHB read data, combinational copy of Prdata

Behaviour:
- Reset: one clock, HCLK; reset is asynchronous and active-low, HRESETn.
- While HRESETn=0 (asserted asynchronously, including mid-transfer): state=IDLE, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1. Any in-flight APB transfer is abandoned.
- Outputs: all outputs except Hrdata are registered. Each is loaded on the edge that enters a state, from that transition's source values.
- States: IDLE, WWAIT, READ, WRITE, WRITEP, RENABLE, WENABLE, WENABLEP.
- Transitions:
  - IDLE, RENABLE, WENABLE: valid&Hwrite -> WWAIT; valid&!Hwrite -> READ; else -> IDLE.
  - WWAIT: valid -> WRITEP; else -> WRITE.
  - READ -> RENABLE.
  - WRITE: valid -> WENABLEP; else -> WENABLE.
  - WRITEP -> WENABLEP.
  - WENABLEP: !Hwrite_reg -> READ; valid&Hwrite_reg -> WRITEP; !valid&Hwrite_reg -> WRITE.
- Output loads on entry:
  - READ: Paddr<=Haddr, Pwrite<=0, Pselx<=decode(Haddr), Penable<=0, Hreadyout<=0.
  - WWAIT: Pselx<=0, Penable<=0, Hreadyout<=1 (captures write data beat).
  - WRITE/WRITEP from WWAIT: Paddr<=Haddr1, Pwdata<=Hwdata, Pwrite<=1, Pselx<=decode(Haddr1), Penable<=0.
  - WRITE/WRITEP from WENABLEP: Paddr<=Haddr2, Pwdata<=Hwdata1, with the same other loads.
  - Hreadyout on entering WRITE/WRITEP: 0 in WRITEP (holds off the next beat), 1 in WRITE.
  - RENABLE, WENABLE, WENABLEP: Penable<=1; Paddr, Pwdata, Pwrite and Pselx held; Hreadyout<=1.
  - IDLE: Pselx<=0, Penable<=0, Hreadyout<=1; Paddr, Pwdata and Pwrite hold their last value.
- Latency:
  - Read: SETUP the cycle after valid is accepted; ENABLE the next cycle. Hrdata is valid during ENABLE.
  - Write: one extra cycle (WWAIT) for the AHB data phase.
- APB protocol rules:
  - Penable=1 only in the cycle immediately following a SETUP cycle with the same Pselx.
  - Paddr, Pwrite and Pwdata are stable across SETUP and ENABLE.
  - Every APB transfer is exactly 2 cycles (no PREADY wait states).
- Out-of-map address: decode returns 0; the FSM still sequences, and Pselx stays 0.
- A read following a write (WENABLEP with !Hwrite_reg) goes directly to READ with no IDLE gap.

Decomposition:
- Shared package ahb_apb_pkg holds:
  - state enum (8 states, 3-bit);
  - address-map constants: 8000_0000, 8400_0000, 8800_0000, 8C00_0000;
  - function decode(addr) returning the one-hot select, with lower bound inclusive and upper bound exclusive per slot.
- Same package constants to be used by ahb_slave_interface.
- No sub-module: single FSM with next-state logic plus a registered output block.

Test Plan:
- Single write, Haddr=8000_0010, Hwdata=DEADBEEF:
  - states IDLE->WWAIT->WRITE->WENABLE->IDLE;
  - SETUP cycle: Pselx=001, Pwrite=1, Paddr=8000_0010, Pwdata=DEADBEEF, Penable=0;
  - next cycle Penable=1, then Pselx=0.
- Single read, Haddr=8400_0004, Prdata=1234_5678:
  - READ cycle: Pselx=010, Pwrite=0, Hreadyout=0;
  - RENABLE: Penable=1, Hrdata=1234_5678, Hreadyout=1.
- Three back-to-back writes to 8800_0000/4/8 with data 1/2/3:
  - path WWAIT->WRITEP->WENABLEP->WRITEP->WENABLEP->WRITE->WENABLE;
  - APB sees three SETUP/ENABLE pairs in order with matching address/data, Pselx=100;
  - Hreadyout=0 in each WRITEP.
- Write to 8000_0000 immediately followed by a read of 8000_0004: WENABLEP->READ; read SETUP Paddr=8000_0004, Pwrite=0.
- HRESETn pulsed low during RENABLE of a read: outputs clear asynchronously (Penable=0, Pselx=0, Hreadyout=1); after release, IDLE and a new read completes normally.
- Address 9000_0000 with valid forced high: full 2-phase sequence with Pselx=000 throughout; no peripheral selected.
